mips_mem_arbiter: RTL and testbench

Arbiter and sequencer that shares a single-port unified memory between the pipelined MIPS instruction-fetch stage and the MEM stage. It grants one requester at a time, holds the memory handshake until the memory completes, and returns read data plus a one-cycle completion pulse. It generates the per-port stall signals that freeze the pipeline while an access is outstanding. Data accesses win by default, with a bounded starvation guard for fetch.

---
 rtl/mips_mem_pkg.sv | 21 ++
 rtl/mips_mem_arbiter_if.sv | 54 +++++
 rtl/mips_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Purpose  : Shared types and default widths for the MIPS unified-memory
//            arbiter, datapath and memory models.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Arbiter sequencing states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_arbiter_if
// Purpose  : Bundles the fetch port, data port and unified-memory port seen
//            by the arbiter. slave = arbiter view, master = pipeline/memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_mem_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  // instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  // MEM-stage data port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              dm_stall;

  // unified single-port memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // the arbiter itself
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // the pipeline stages and the memory around it
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_arbiter
// Purpose  : Shares one single-port memory between MIPS fetch and MEM stages.
//            Data wins by default; a streak counter bounds fetch starvation.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_DM_STREAK = 4
) (
  input wire logic         clk,
  input wire logic         rst,
  mips_mem_arbiter_if.slave bus
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(MAX_DM_STREAK);

  generate
    if (MAX_DM_STREAK < 1) begin : g_bad_streak
      $error("MAX_DM_STREAK must be at least 1");
    end
  endgenerate

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic [STREAK_W-1:0] r_streak;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_if_done;
  logic                r_dm_done;

  logic                w_if_elig;
  logic                w_dm_elig;
  logic                w_dm_wins;
  logic                w_grant_if;
  logic                w_grant_dm;
  logic                w_if_cpl;
  logic                w_dm_cpl;

  // A request whose done is pulsing this cycle is already served; masking it
  // here keeps the done/IDLE cycle from re-granting the same access.
  assign w_if_elig = bus.if_req & ~r_if_done;
  assign w_dm_elig = bus.dm_req & ~r_dm_done;
  assign w_dm_wins = w_dm_elig & (~w_if_elig | (r_streak < c_streak_max));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state: arbitrate in IDLE, wait for the memory in BUSY
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_dm_wins)      w_next_state = BUSY_DM;
        else if (w_if_elig) w_next_state = BUSY_IF;
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: grant strobes in IDLE, completion strobes in BUSY
  always_comb begin
    w_grant_dm = 1'b0;
    w_grant_if = 1'b0;
    w_if_cpl   = 1'b0;
    w_dm_cpl   = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_dm = w_dm_wins;
        w_grant_if = ~w_dm_wins & w_if_elig;
      end
      BUSY_IF: w_if_cpl = bus.mem_ready;
      BUSY_DM: w_dm_cpl = bus.mem_ready;
      default: ;
    endcase
  end

  // Memory-side request: latched on grant, held until the memory completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_dm) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= bus.dm_we;
      r_mem_addr  <= bus.dm_addr;
      r_mem_wdata <= bus.dm_wdata;
    end else if (w_grant_if) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= bus.if_addr;
    end else if (w_if_cpl | w_dm_cpl) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Completion pulses and returned read data; a store leaves dm_rdata alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_done  <= 1'b0;
      r_dm_done  <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_done <= w_if_cpl;
      r_dm_done <= w_dm_cpl;
      if (w_if_cpl)             r_if_rdata <= bus.mem_rdata;
      if (w_dm_cpl & ~r_mem_we) r_dm_rdata <= bus.mem_rdata;
    end
  end

  // Starvation guard: counts data grants that overtook a waiting fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (w_grant_if) begin
      r_streak <= '0;
    end else if (w_grant_dm & w_if_elig & (r_streak < c_streak_max)) begin
      r_streak <= r_streak + STREAK_W'(1);
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.dm_done   = r_dm_done;
  assign bus.if_stall  = bus.if_req & ~r_if_done;
  assign bus.dm_stall  = bus.dm_req & ~r_dm_done;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mem_arbiter
// Purpose  : Self-checking bench for mips_mem_arbiter: behavioural memory,
//            per-port result scoreboards and a grant-order log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sb_if[$];        // expected if_rdata per fetch completion
  logic [31:0] sb_dm[$];        // expected dm_rdata per data completion
  bit          grants[$];       // 1 = data grant, 0 = fetch grant
  int          n_if_done = 0;
  int          n_dm_done = 0;
  logic [31:0] mem_model [logic [31:0]];
  int          lat = 3;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fill(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : fill(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit dm);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dm ? bus.dm_done : bus.if_done) begin
        ok = 1'b1;
        break;
      end
    end
    check(dm ? "dm_done_seen" : "if_done_seen", ok, 1);
  endtask

  // Memory: answers after `lat` cycles of mem_req, checks request stability
  initial begin : p_memory
    int          age;
    logic [31:0] l_addr, l_wdata;
    logic        l_we;
    age = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0BAD_F00D;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0BAD_F00D;
      if (rst || !bus.mem_req) begin
        age = 0;
      end else begin
        age++;
        if (age == 1) begin
          l_addr  = bus.mem_addr;
          l_we    = bus.mem_we;
          l_wdata = bus.mem_wdata;
        end else begin
          check("mem_addr_stable", bus.mem_addr, l_addr);
          check("mem_we_stable", bus.mem_we, l_we);
          if (l_we) check("mem_wdata_stable", bus.mem_wdata, l_wdata);
        end
        if (age == lat) begin
          if (l_we) mem_model[l_addr] = l_wdata;
          else      bus.mem_rdata = rd(l_addr);
          bus.mem_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: logs grants, pops scoreboards on every done pulse
  initial begin : p_monitor
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_req && !prev_req) grants.push_back(bus.mem_addr >= 32'h100);
        if (bus.if_done) begin
          n_if_done++;
          check("if_done_expected", sb_if.size() > 0, 1);
          if (sb_if.size() > 0) check("if_rdata", bus.if_rdata, sb_if.pop_front());
        end
        if (bus.dm_done) begin
          n_dm_done++;
          check("done_exclusive", bus.if_done, 0);
          check("dm_done_expected", sb_dm.size() > 0, 1);
          if (sb_dm.size() > 0) check("dm_rdata", bus.dm_rdata, sb_dm.pop_front());
        end
      end
      prev_req = bus.mem_req;
    end
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_main
    int          n_hi, n_stall, n_done_before;
    bit          ok;
    logic [31:0] exp_dm;
    bit          exp_g[$];

    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    mem_model[32'h40] = 32'h8C22_0004;
    exp_dm = 32'h0;
    tick(); tick();

    // reset state
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);
    check("rst_dones", {bus.if_done, bus.dm_done}, 0);
    rst = 1'b0;
    tick();

    // single fetch, memory answers on the third request cycle
    lat = 3;
    bus.if_req = 1; bus.if_addr = 32'h40;
    sb_if.push_back(32'h8C22_0004);
    n_hi = 0; n_stall = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.if_done) begin ok = 1; break; end
      if (bus.mem_req) begin
        n_hi++;
        if (bus.if_stall) n_stall++;
      end
    end
    check("fetch_done_seen", ok, 1);
    check("fetch_mem_req_cycles", n_hi, 3);
    check("fetch_stall_cycles", n_stall, 3);
    check("fetch_stall_in_done", bus.if_stall, 0);
    check("fetch_mem_req_in_done", bus.mem_req, 0);
    tick(); bus.if_req = 0;
    @(negedge clk);
    check("fetch_done_single", bus.if_done, 0);

    // store then load, latency 1
    tick(); lat = 1;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF;
    sb_dm.push_back(exp_dm);
    @(negedge clk);
    check("store_stall_pending", bus.dm_stall, 1);
    @(negedge clk);
    check("store_mem_req", bus.mem_req, 1);
    check("store_mem_we", bus.mem_we, 1);
    check("store_mem_addr", bus.mem_addr, 32'h100);
    check("store_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    wait_done(1);
    check("store_stall_in_done", bus.dm_stall, 0);
    tick(); bus.dm_we = 0; bus.dm_wdata = 0;
    sb_dm.push_back(32'hDEAD_BEEF);
    wait_done(1);
    tick(); bus.dm_req = 0;
    exp_dm = 32'hDEAD_BEEF;

    // simultaneous first requests: DM first, IF in the dm_done cycle
    tick(); lat = 2; grants.delete();
    bus.if_req = 1; bus.if_addr = 32'h44;
    bus.dm_req = 1; bus.dm_addr = 32'h200;
    sb_if.push_back(fill(32'h44));
    sb_dm.push_back(fill(32'h200));
    wait_done(1);
    tick(); bus.dm_req = 0;
    @(negedge clk);
    check("simul_if_granted", bus.mem_req, 1);
    check("simul_if_addr", bus.mem_addr, 32'h44);
    wait_done(0);
    tick(); bus.if_req = 0;
    tick(); tick();
    exp_dm = fill(32'h200);
    exp_g = '{1'b1, 1'b0};
    check("simul_grant_count", grants.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < grants.size(); i++)
      check($sformatf("simul_grant%0d", i), grants[i], exp_g[i]);

    // starvation guard: fetch eligible at four data grants, then it must win
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.if_req = 1; bus.if_addr = 32'h48;
      bus.dm_req = 1; bus.dm_addr = 32'h300 + 32'(4 * i);
      sb_dm.push_back(fill(32'h300 + 32'(4 * i)));
      tick();
      bus.if_req = 0;
      wait_done(1);
      tick(); bus.dm_req = 0;
    end
    tick();
    bus.if_req = 1; bus.if_addr = 32'h4C;
    bus.dm_req = 1; bus.dm_addr = 32'h310;
    sb_if.push_back(fill(32'h4C));
    sb_dm.push_back(fill(32'h310));
    wait_done(0);
    tick(); bus.if_req = 0;
    wait_done(1);
    tick(); bus.dm_req = 0;
    tick();
    exp_dm = fill(32'h310);
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    check("streak_grant_count", grants.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < grants.size(); i++)
      check($sformatf("streak_grant%0d", i), grants[i], exp_g[i]);

    // held contention: requests re-asserted straight after each done
    grants.delete();
    tick();
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          bus.if_addr = 32'h50 + 32'(4 * k);
          sb_if.push_back(fill(32'h50 + 32'(4 * k)));
          bus.if_req = 1;
          wait_done(0);
          tick();
        end
        bus.if_req = 0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          bus.dm_addr = 32'h400 + 32'(4 * k);
          sb_dm.push_back(fill(32'h400 + 32'(4 * k)));
          bus.dm_req = 1;
          wait_done(1);
          tick();
        end
        bus.dm_req = 0;
      end
    join
    tick();
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    check("contend_grant_count", grants.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < grants.size(); i++)
      check($sformatf("contend_grant%0d", i), grants[i], exp_g[i]);

    // flush: data request dropped while the access is in flight
    tick(); lat = 3; grants.delete();
    n_done_before = n_dm_done;
    bus.dm_req = 1; bus.dm_addr = 32'h500;
    sb_dm.push_back(fill(32'h500));
    tick(); tick();
    bus.dm_req = 0;
    wait_done(1);
    n_hi = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_req) n_hi++;
    end
    check("flush_no_regrant", n_hi, 0);
    check("flush_grant_count", grants.size(), 1);
    check("flush_done_once", n_dm_done - n_done_before, 1);
    exp_dm = fill(32'h500);

    // reset two cycles into a fetch
    tick(); lat = 6;
    n_done_before = n_if_done;
    bus.if_req = 1; bus.if_addr = 32'h60;
    sb_if.push_back(fill(32'h60));
    tick();
    @(negedge clk); @(negedge clk);
    check("pre_rst_busy", bus.mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_mem_req", bus.mem_req, 0);
    check("async_mem_addr", bus.mem_addr, 0);
    check("async_mem_we", bus.mem_we, 0);
    check("async_mem_wdata", bus.mem_wdata, 0);
    check("async_if_rdata", bus.if_rdata, 0);
    check("async_dm_rdata", bus.dm_rdata, 0);
    check("async_dones", {bus.if_done, bus.dm_done}, 0);
    sb_if.delete();
    bus.if_req = 0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("rst_no_if_done", n_if_done - n_done_before, 0);
    tick();
    bus.if_req = 1; bus.if_addr = 32'h40;
    sb_if.push_back(32'h8C22_0004);
    wait_done(0);
    tick(); bus.if_req = 0;
    tick(); tick();

    check("sb_if_drained", sb_if.size(), 0);
    check("sb_dm_drained", sb_dm.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
